// File: rtl/wptr_full_if.sv
// wptr_full_if
//   Bundles the write-side FIFO pointer signals between the write-domain
//   logic (master: issues writes, supplies the synchronised read pointer)
//   and the write pointer / full-flag handler (slave).
//   Signals:
//     winc         write request
//     wq2_rptr     Gray read pointer already synchronised into wclk
//     wovf_clr     clears the sticky overflow flag
//     waddr        memory write address
//     wen          memory write enable
//     wptr         Gray write pointer, registered
//     wfull        FIFO full, registered
//     walmost_full fill level >= threshold, registered
//     wlevel       write-side fill estimate, registered
//     woverflow    sticky: write attempted while full
interface wptr_full_if #(
  parameter int ADDR_SIZE = 4
);
  logic                 winc;
  logic [ADDR_SIZE:0]   wq2_rptr;
  logic                 wovf_clr;
  logic [ADDR_SIZE-1:0] waddr;
  logic                 wen;
  logic [ADDR_SIZE:0]   wptr;
  logic                 wfull;
  logic                 walmost_full;
  logic [ADDR_SIZE:0]   wlevel;
  logic                 woverflow;

  modport master (
    output winc, wq2_rptr, wovf_clr,
    input  waddr, wen, wptr, wfull, walmost_full, wlevel, woverflow
  );

  modport slave (
    input  winc, wq2_rptr, wovf_clr,
    output waddr, wen, wptr, wfull, walmost_full, wlevel, woverflow
  );
endinterface

// File: rtl/wptr_full.sv
// wptr_full
//   Write-clock-domain pointer and full-flag handler of an asynchronous FIFO.
//   Keeps a binary write counter, exports it as a Gray pointer, compares it
//   with the synchronised read pointer and produces registered full,
//   almost-full, fill level and sticky overflow status.
//   Ports:
//     wclk    write clock
//     wrst_n  asynchronous active-low reset
//     bus     wptr_full_if.slave (winc, wq2_rptr, wovf_clr in;
//             waddr, wen, wptr, wfull, walmost_full, wlevel, woverflow out)
module wptr_full #(
  parameter int ADDR_SIZE    = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic          wclk,
  input  logic          wrst_n,
  wptr_full_if.slave    bus
);

  localparam logic [ADDR_SIZE:0] LP_AFULL = (ADDR_SIZE+1)'(AFULL_THRESH);

  logic [ADDR_SIZE:0] r_wbin;
  logic [ADDR_SIZE:0] r_wptr;
  logic [ADDR_SIZE:0] r_wlevel;
  logic               r_wfull;
  logic               r_walmost_full;
  logic               r_woverflow;

  logic               w_winc_ok;
  logic               w_ovf_set;
  logic [ADDR_SIZE:0] w_wbin_next;
  logic [ADDR_SIZE:0] w_wgray_next;
  logic [ADDR_SIZE:0] w_rbin;
  logic [ADDR_SIZE:0] w_level_next;
  logic               w_full_val;

  assign w_winc_ok    = bus.winc & ~r_wfull;
  assign w_ovf_set    = bus.winc & r_wfull;
  assign w_wbin_next  = r_wbin + {{ADDR_SIZE{1'b0}}, w_winc_ok};
  assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;

  // Full when the next write pointer is one lap ahead of the read pointer:
  // in Gray code that is the top two bits inverted, the rest equal.
  assign w_full_val = (w_wgray_next ==
                       {~bus.wq2_rptr[ADDR_SIZE:ADDR_SIZE-1],
                         bus.wq2_rptr[ADDR_SIZE-2:0]});

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_rbin = '0;
    for (int i = 0; i <= ADDR_SIZE; i++) begin
      w_rbin[i] = ^(bus.wq2_rptr >> i);
    end
  end

  // Uses the lagging read pointer, so the level can only be overestimated.
  assign w_level_next = w_wbin_next - w_rbin;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wbin         <= '0;
      r_wptr         <= '0;
      r_wlevel       <= '0;
      r_wfull        <= 1'b0;
      r_walmost_full <= 1'b0;
      r_woverflow    <= 1'b0;
    end else begin
      r_wbin         <= w_wbin_next;
      r_wptr         <= w_wgray_next;
      r_wlevel       <= w_level_next;
      r_wfull        <= w_full_val;
      r_walmost_full <= (w_level_next >= LP_AFULL);
      // Set has priority over clear.
      r_woverflow    <= w_ovf_set | (r_woverflow & ~bus.wovf_clr);
    end
  end

  assign bus.waddr        = r_wbin[ADDR_SIZE-1:0];
  assign bus.wen          = w_winc_ok;
  assign bus.wptr         = r_wptr;
  assign bus.wfull        = r_wfull;
  assign bus.walmost_full = r_walmost_full;
  assign bus.wlevel       = r_wlevel;
  assign bus.woverflow    = r_woverflow;

endmodule

// File: tb/tb_wptr_full.sv
module tb_wptr_full;

  logic wclk = 1'b0;
  logic wrst_n = 1'b0;
  always #5 wclk = ~wclk;

  wptr_full_if #(.ADDR_SIZE(4)) bus ();

  wptr_full #(.ADDR_SIZE(4), .AFULL_THRESH(12)) u_dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       inc;
    logic       clr;
    logic [4:0] rd_gray;
    logic       exp_wen;
    logic [3:0] exp_waddr;
    logic [4:0] exp_wptr;
    logic       exp_full;
    logic       exp_afull;
    logic [4:0] exp_level;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[$];

  // reference model: unbounded write/read counts since reset
  int m_w = 0;
  int m_r = 0;
  bit m_ovf = 1'b0;
  bit m_full = 1'b0;

  function automatic logic [4:0] gray5(int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all_regs(string tag, logic [3:0] waddr, logic [4:0] wptr,
                              logic full, logic afull, logic [4:0] level, logic ovf);
    chk({tag, ".waddr"}, int'(bus.waddr), int'(waddr));
    chk({tag, ".wptr"}, int'(bus.wptr), int'(wptr));
    chk({tag, ".wfull"}, int'(bus.wfull), int'(full));
    chk({tag, ".walmost_full"}, int'(bus.walmost_full), int'(afull));
    chk({tag, ".wlevel"}, int'(bus.wlevel), int'(level));
    chk({tag, ".woverflow"}, int'(bus.woverflow), int'(ovf));
  endtask

  task automatic model_reset();
    m_w = 0; m_r = 0; m_ovf = 1'b0; m_full = 1'b0;
  endtask

  // One model-checked cycle; entered and left at a falling edge.
  task automatic cyc(input logic inc, input logic clr, input int rd);
    int lvl;
    bus.winc     = inc;
    bus.wovf_clr = clr;
    m_r          = rd;
    bus.wq2_rptr = gray5(rd % 32);
    #1;
    chk("m.wen", int'(bus.wen), int'(inc && !m_full));
    chk("m.waddr_pre", int'(bus.waddr), m_w % 16);
    @(posedge wclk);
    if (inc && !m_full) m_w++;
    m_ovf  = (inc && m_full) || (m_ovf && !clr);
    lvl    = m_w - m_r;
    m_full = (lvl == 16);
    #1;
    chk_all_regs("m", 4'(m_w % 16), gray5(m_w % 32), m_full, lvl >= 12, 5'(lvl), m_ovf);
    @(negedge wclk);
  endtask

  initial begin
    vec_t v;
    logic [4:0] prev_wptr;
    logic [3:0] prev_waddr;
    bit saw_wrap;
    int rd;

    // fill from empty with read pointer at 0
    for (int i = 1; i <= 16; i++) begin
      v = '{1'b1, 1'b0, 5'b00000, 1'b1, 4'(i % 16), gray5(i),
            (i == 16), (i >= 12), 5'(i), 1'b0};
      vecs.push_back(v);
    end
    // overflow attempts and clears while full
    vecs.push_back('{1'b1, 1'b0, 5'b00000, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 5'b00000, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 5'b00000, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 5'b00000, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 5'b00000, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 5'b00000, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b0});
    // reader advances to 4 (Gray 00110), then refill to full and overflow
    vecs.push_back('{1'b0, 1'b0, 5'b00110, 1'b0, 4'd0, 5'b11000, 1'b0, 1'b1, 5'd12, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 5'b00110, 1'b1, 4'd1, 5'b11001, 1'b0, 1'b1, 5'd13, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 5'b00110, 1'b1, 4'd2, 5'b11011, 1'b0, 1'b1, 5'd14, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 5'b00110, 1'b1, 4'd3, 5'b11010, 1'b0, 1'b1, 5'd15, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 5'b00110, 1'b1, 4'd4, 5'b11110, 1'b1, 1'b1, 5'd16, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 5'b00110, 1'b0, 4'd4, 5'b11110, 1'b1, 1'b1, 5'd16, 1'b1});

    // reset with winc held high
    bus.winc = 1'b1; bus.wovf_clr = 1'b0; bus.wq2_rptr = '0;
    #12;
    chk_all_regs("rst", 4'd0, 5'b00000, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("rst.wen", int'(bus.wen), 1);
    @(negedge wclk);
    wrst_n = 1'b1;

    foreach (vecs[k]) begin
      bus.winc     = vecs[k].inc;
      bus.wovf_clr = vecs[k].clr;
      bus.wq2_rptr = vecs[k].rd_gray;
      #1;
      chk($sformatf("v%0d.wen", k), int'(bus.wen), int'(vecs[k].exp_wen));
      @(posedge wclk);
      #1;
      chk_all_regs($sformatf("v%0d", k), vecs[k].exp_waddr, vecs[k].exp_wptr,
                   vecs[k].exp_full, vecs[k].exp_afull, vecs[k].exp_level, vecs[k].exp_ovf);
      @(negedge wclk);
    end

    // asynchronous reset mid-cycle while full and overflowed
    #2;
    bus.winc = 1'b0;
    wrst_n = 1'b0;
    #1;
    chk_all_regs("arst", 4'd0, 5'b00000, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("arst.wen", int'(bus.wen), 0);
    @(negedge wclk);
    wrst_n = 1'b1;
    model_reset();
    cyc(1'b1, 1'b0, 0);
    chk("arst.first_wptr", int'(bus.wptr), 5'b00001);

    // continuous write, reader trailing so the level settles at 3
    saw_wrap = 1'b0;
    for (int i = 0; i < 70; i++) begin
      prev_wptr  = bus.wptr;
      prev_waddr = bus.waddr;
      rd = (m_w >= 2) ? m_w - 2 : 0;
      cyc(1'b1, 1'b0, rd);
      chk("wrap.gray_step", $countones(bus.wptr ^ prev_wptr), 1);
      if (prev_waddr == 4'd15 && bus.waddr == 4'd0) saw_wrap = 1'b1;
      if (i >= 2) chk("wrap.level", int'(bus.wlevel), 3);
      chk("wrap.no_afull", int'(bus.walmost_full | bus.wfull), 0);
    end
    chk("wrap.seen", int'(saw_wrap), 1);
    chk("wrap.wbin_wrapped", int'(m_w > 64), 1);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic inc;
      logic clr;
      rd = m_r;
      inc = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) begin
        rd = m_r + $urandom_range(0, 3);
        if (rd > m_w) rd = m_w;
      end
      cyc(inc, clr, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wptr_full.md
Name: wptr_full

Overview:
Write-side pointer and full-flag handler for the asynchronous FIFO. It is the write-clock-domain counterpart of the read-pointer/empty handler.
- Keeps a binary write counter and exports it as a Gray-coded pointer for synchronisation into the read domain.
- Compares it against the read pointer already synchronised into the write domain.
- Produces registered full, almost-full, fill-level and sticky overflow status, plus the memory write address and enable.

Parameters:
ADDR_SIZE, 4, FIFO address width; depth = 2**ADDR_SIZE; must be >= 2
AFULL_THRESH, 12, almost-full asserts when fill level >= this value; legal range 1..2**ADDR_SIZE

Ports:
wclk  input  1  write clock
wrst_n  input  1  asynchronous active-low reset
winc  input  1  write request
wq2_rptr  input  ADDR_SIZE+1  read pointer, Gray code, already synchronised to wclk
wovf_clr  input  1  clears sticky overflow flag
waddr  output  ADDR_SIZE  memory write address
wen  output  1  memory write enable, combinational = winc & ~wfull
wptr  output  ADDR_SIZE+1  write pointer, Gray code, registered
wfull  output  1  FIFO full, registered
walmost_full  output  1  fill level >= AFULL_THRESH, registered
wlevel  output  ADDR_SIZE+1  write-side fill estimate 0..2**ADDR_SIZE, registered
woverflow  output  1  sticky: write attempted while full

Behaviour:
- One clock, wclk. Reset is asynchronous and active-low on wrst_n. All registers clear immediately when wrst_n falls, independent of wclk.
- Reset values: wbin=0, wptr=0, waddr=0, wfull=0, walmost_full=0, wlevel=0, woverflow=0. wen=0 while winc=0.
- Pointer update:
  - wbin_next = wbin + (winc & ~wfull), modulo 2**(ADDR_SIZE+1).
  - wgray_next = (wbin_next>>1) ^ wbin_next.
  - {wbin, wptr} <= {wbin_next, wgray_next} every wclk edge.
- waddr = wbin[ADDR_SIZE-1:0], taken combinationally from the registered binary counter.
- Full flag:
  - wfull_val = (wgray_next == {~wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], wq2_rptr[ADDR_SIZE-2:0]}).
  - wfull <= wfull_val.
  - wfull therefore asserts on the same edge that commits the final write; there is no extra latency.
- Fill level:
  - rbin_sync is the Gray-to-binary conversion of wq2_rptr: bit i = XOR of bits ADDR_SIZE..i.
  - level_next = (wbin_next - rbin_sync) mod 2**(ADDR_SIZE+1).
  - wlevel <= level_next.
  - walmost_full <= (level_next >= AFULL_THRESH).
  - wfull, wlevel and walmost_full are mutually consistent in every cycle: wfull=1 exactly when wlevel = 2**ADDR_SIZE.
- Overflow:
  - An overflow attempt is winc=1 while wfull=1. It causes no pointer movement and wen=0.
  - woverflow <= woverflow_set | (woverflow & ~wovf_clr), where woverflow_set = winc & wfull.
  - If set and clear occur in the same cycle, set wins.
- Conservatism: a read seen late through the synchroniser only delays deassertion of wfull, walmost_full and wlevel. A premature deassertion is a bug.
- Wrap-around: wbin rolls from 2**(ADDR_SIZE+1)-1 to 0 and waddr rolls from 2**ADDR_SIZE-1 to 0 with no glitch on status flags. wptr changes exactly one bit per increment, including at wrap.
- Simultaneous winc with a change in wq2_rptr: both are folded into the same next-state computation. With wfull=0 the write is always accepted.
- Reset mid-operation, including while full or overflowed: all outputs return to their reset values at once. The first write after release goes to waddr=0.

Test Plan:
Parameters for all scenarios: ADDR_SIZE=4, AFULL_THRESH=12.
- Reset with winc=1 held -> waddr=0, wptr=5'b00000, wfull=0, walmost_full=0, wlevel=0, woverflow=0, wen=1 after release.
- 16 consecutive winc with wq2_rptr=0 -> walmost_full rises on the 12th edge (wlevel=12), wfull rises on the 16th edge, wptr=5'b11000, wlevel=16, waddr=0.
- One more winc while full -> wen=0, wptr stays 5'b11000, woverflow=1 next edge and stays 1. wovf_clr=1 for one cycle clears it; wovf_clr and winc together while full keeps woverflow=1.
- From full, drive wq2_rptr=5'b00110 (binary 4) -> next edge wfull=0, wlevel=12, walmost_full=1. One write -> wlevel=13, wfull=0.
- Continuous write with wq2_rptr tracking wbin-3 for 70 cycles -> waddr wraps 15->0 and wbin wraps 31->0, wptr has single-bit Gray steps, wlevel stays 3, wfull and walmost_full never assert.
- wrst_n pulled low asynchronously mid-cycle while wfull=1 and woverflow=1 -> all outputs clear before the next wclk edge. After release the first write lands at waddr=0 and wptr=5'b00001.
